// File: rtl/ser_pkg.sv
// Shared types and build-time helpers for stream_serializer.
// Macro SER_PARITY_EN adds one per-lane even-parity beat after the data beats.
package ser_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StShift = 1'b1
  } ser_state_e;

  // Bit n set when n is a legal lane count (1, 2, 4, 8).
  localparam logic [8:0] SER_LEGAL_LANES = 9'b1_0001_0110;

  function automatic int unsigned ser_beats(input int unsigned data_w, input int unsigned lanes);
`ifdef SER_PARITY_EN
    return data_w / lanes + 1;
`else
    return data_w / lanes;
`endif
  endfunction

  function automatic int unsigned ser_cnt_w(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/ser_beat_counter.sv
// Synchronous-reset modulo-BEATS beat counter; load restarts at beat 0.
module ser_beat_counter #(
  parameter int unsigned BEATS = 16,
  parameter int unsigned CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic             i_enable,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_last
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == CNT_W'(BEATS - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset || i_load) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_last = w_last;

endmodule

// File: rtl/stream_serializer.sv
// Single-clock parallel-to-serial converter with valid/ready input and gapless reload.
// Define SER_PARITY_EN to append a per-lane even-parity beat to every word.
module stream_serializer
  import ser_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned LANES     = 1,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] PAR_IN,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic [LANES-1:0]  SERIAL_OUT,
  output logic              OUT_VALID,
  output logic              FRAME_START,
  output logic              BUSY
);

  localparam int unsigned BEATS = ser_beats(DATA_W, LANES);
  localparam int unsigned CNT_W = ser_cnt_w(BEATS);

  if ((LANES > 8) || !SER_LEGAL_LANES[LANES[3:0]]) begin : g_bad_lanes
    $error("stream_serializer: LANES must be 1, 2, 4 or 8");
  end
  if ((DATA_W % LANES) != 0) begin : g_bad_width
    $error("stream_serializer: DATA_W must be a multiple of LANES");
  end

  ser_state_e       r_state, w_state_next;
  logic [DATA_W-1:0] r_shift;
  logic [LANES-1:0]  r_serial;
  logic              r_out_valid;
  logic              r_frame_start;

  logic [CNT_W-1:0]  w_cnt;
  logic              w_last;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_advance;
  logic [LANES-1:0]  w_load_beat;
  logic [LANES-1:0]  w_next_beat;
  logic [DATA_W-1:0] w_load_rest;
  logic [DATA_W-1:0] w_shift_rest;

  assign w_in_ready = !RESET && ((r_state == StIdle) ||
                                 ((r_state == StShift) && (w_cnt == CNT_W'(BEATS - 1))));
  assign w_accept   = IN_VALID && w_in_ready;
  assign w_advance  = (r_state == StShift) && !w_last;

  // The shift register keeps only the beats still to be sent, next one at the exit end.
  assign w_load_beat  = MSB_FIRST ? PAR_IN[DATA_W-1 -: LANES]  : PAR_IN[LANES-1:0];
  assign w_next_beat  = MSB_FIRST ? r_shift[DATA_W-1 -: LANES] : r_shift[LANES-1:0];
  assign w_load_rest  = MSB_FIRST ? (PAR_IN << LANES)  : (PAR_IN >> LANES);
  assign w_shift_rest = MSB_FIRST ? (r_shift << LANES) : (r_shift >> LANES);

  ser_beat_counter #(
    .BEATS (BEATS),
    .CNT_W (CNT_W)
  ) u_beat_counter (
    .i_clk    (CLK),
    .i_reset  (RESET),
    .i_load   (w_accept),
    .i_enable ((r_state == StShift) && !w_accept),
    .o_cnt    (w_cnt),
    .o_last   (w_last)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_next = StShift;
      StShift: if (w_last && !w_accept) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

`ifdef SER_PARITY_EN
  localparam int unsigned DBEATS = DATA_W / LANES;

  // XOR of every data beat presented so far in the current word.
  logic [LANES-1:0] r_par;
  logic             w_data_done;

  assign w_data_done = (w_cnt == CNT_W'(DBEATS - 1));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_par <= '0;
    end else if (w_accept) begin
      r_par <= w_load_beat;
    end else if (w_advance && !w_data_done) begin
      r_par <= r_par ^ w_next_beat;
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_shift       <= '0;
      r_serial      <= '0;
      r_out_valid   <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (w_accept) begin
      r_shift       <= w_load_rest;
      r_serial      <= w_load_beat;
      r_out_valid   <= 1'b1;
      r_frame_start <= 1'b1;
    end else if (w_advance) begin
      r_out_valid   <= 1'b1;
      r_frame_start <= 1'b0;
`ifdef SER_PARITY_EN
      if (w_data_done) begin
        r_serial <= r_par;
      end else begin
        r_serial <= w_next_beat;
        r_shift  <= w_shift_rest;
      end
`else
      r_serial <= w_next_beat;
      r_shift  <= w_shift_rest;
`endif
    end else begin
      r_serial      <= '0;
      r_out_valid   <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  assign IN_READY    = w_in_ready;
  assign SERIAL_OUT  = r_serial;
  assign OUT_VALID   = r_out_valid;
  assign FRAME_START = r_frame_start;
  assign BUSY        = (r_state == StShift);

endmodule

// File: tb/tb_stream_serializer.sv
// Directed bench: one single-lane DUT plus LSB-first and MSB-first four-lane DUTs.
module tb_stream_serializer;

`ifdef SER_PARITY_EN
  localparam int unsigned PAR = 1;
`else
  localparam int unsigned PAR = 0;
`endif
  localparam int unsigned BA = 16 + PAR;
  localparam int unsigned B4 = 4 + PAR;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] a_par;
  logic        a_valid;
  logic        a_ready, a_ov, a_fs, a_busy;
  logic [0:0]  a_ser;
  logic [15:0] q_par;
  logic        q_valid;
  logic        l_ready, l_ov, l_fs, l_busy;
  logic [3:0]  l_ser;
  logic        m_ready, m_ov, m_fs, m_busy;
  logic [3:0]  m_ser;

  stream_serializer #(.DATA_W(16), .LANES(1), .MSB_FIRST(1'b0)) u_dut_a (
    .CLK(clk), .RESET(rst), .PAR_IN(a_par), .IN_VALID(a_valid), .IN_READY(a_ready),
    .SERIAL_OUT(a_ser), .OUT_VALID(a_ov), .FRAME_START(a_fs), .BUSY(a_busy)
  );
  stream_serializer #(.DATA_W(16), .LANES(4), .MSB_FIRST(1'b0)) u_dut_l (
    .CLK(clk), .RESET(rst), .PAR_IN(q_par), .IN_VALID(q_valid), .IN_READY(l_ready),
    .SERIAL_OUT(l_ser), .OUT_VALID(l_ov), .FRAME_START(l_fs), .BUSY(l_busy)
  );
  stream_serializer #(.DATA_W(16), .LANES(4), .MSB_FIRST(1'b1)) u_dut_m (
    .CLK(clk), .RESET(rst), .PAR_IN(q_par), .IN_VALID(q_valid), .IN_READY(m_ready),
    .SERIAL_OUT(m_ser), .OUT_VALID(m_ov), .FRAME_START(m_fs), .BUSY(m_busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Beat k lives at bits [4k+3:4k]; bits [19:16] hold the parity beat.
  typedef struct {
    logic [15:0] word;
    logic [19:0] lsb;
    logic [19:0] msb;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [15:0] w;
    logic        exp_bit;

    vecs[0] = '{word: 16'h1234, lsb: 20'h4_1234, msb: 20'h4_4321};
    vecs[1] = '{word: 16'hA5C3, lsb: 20'h0_A5C3, msb: 20'h0_3C5A};
    vecs[2] = '{word: 16'hFFFF, lsb: 20'h0_FFFF, msb: 20'h0_FFFF};
    vecs[3] = '{word: 16'h0F0E, lsb: 20'h1_0F0E, msb: 20'h1_E0F0};

    rst = 1'b1; a_valid = 1'b0; a_par = '0; q_valid = 1'b0; q_par = '0;
    step(); step();
    chk("rst_ov",    32'(a_ov),    32'd0);
    chk("rst_ser",   32'(a_ser),   32'd0);
    chk("rst_fs",    32'(a_fs),    32'd0);
    chk("rst_busy",  32'(a_busy),  32'd0);
    chk("rst_ready", 32'(a_ready), 32'd0);
    chk("rst_ready4", 32'(l_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(a_ready), 32'd1);

    // Four-lane table, both bit orders.
    for (int v = 0; v < 4; v++) begin
      q_valid = 1'b1; q_par = vecs[v].word;
      chk("tab_ready_l", 32'(l_ready), 32'd1);
      chk("tab_ready_m", 32'(m_ready), 32'd1);
      step();
      q_valid = 1'b0;
      for (int k = 0; k < int'(B4); k++) begin
        chk("tab_ov",   32'(l_ov && m_ov), 32'd1);
        chk("tab_fs",   32'(l_fs), 32'(k == 0));
        chk("tab_fs_m", 32'(m_fs), 32'(k == 0));
        chk("tab_busy", 32'(l_busy), 32'd1);
        chk("tab_lsb",  32'(l_ser), 32'(vecs[v].lsb[k*4 +: 4]));
        chk("tab_msb",  32'(m_ser), 32'(vecs[v].msb[k*4 +: 4]));
        step();
      end
      chk("tab_end_ov",   32'(l_ov || m_ov), 32'd0);
      chk("tab_end_ser",  32'(l_ser | m_ser), 32'd0);
      chk("tab_end_busy", 32'(l_busy), 32'd0);
    end

    // Single lane, LSB first: A5C3 -> 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 (+ parity 0).
    w = 16'hA5C3;
    a_valid = 1'b1; a_par = w;
    step();
    a_valid = 1'b0;
    for (int k = 0; k < int'(BA); k++) begin
      exp_bit = (k < 16) ? w[k] : 1'b0;
      chk("a5_ov",  32'(a_ov), 32'd1);
      chk("a5_fs",  32'(a_fs), 32'(k == 0));
      chk("a5_ser", 32'(a_ser), 32'(exp_bit));
      step();
    end
    chk("a5_end_ov", 32'(a_ov), 32'd0);

    // Gapless back-to-back: FFFF then 0000 with IN_VALID held.
    a_valid = 1'b1; a_par = 16'hFFFF;
    step();
    a_par = 16'h0000;
    for (int c = 0; c < int'(2 * BA); c++) begin
      exp_bit = (c < int'(BA)) && ((c % int'(BA)) < 16);
      chk("gap_ov",    32'(a_ov), 32'd1);
      chk("gap_fs",    32'(a_fs), 32'((c == 0) || (c == int'(BA))));
      chk("gap_ser",   32'(a_ser), 32'(exp_bit));
      chk("gap_ready", 32'(a_ready), 32'((c % int'(BA)) == int'(BA) - 1));
      if (c == int'(BA)) a_valid = 1'b0;
      step();
    end
    chk("gap_end_ov",    32'(a_ov), 32'd0);
    chk("gap_end_ready", 32'(a_ready), 32'd1);

    // Reset at beat 5 of a word.
    a_valid = 1'b1; a_par = 16'hA5C3;
    step();
    a_valid = 1'b0;
    repeat (5) step();
    chk("mid_ov_b5",  32'(a_ov), 32'd1);
    chk("mid_ser_b5", 32'(a_ser), 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_ready_in_rst", 32'(a_ready), 32'd0);
    step();
    chk("mid_ov",   32'(a_ov), 32'd0);
    chk("mid_ser",  32'(a_ser), 32'd0);
    chk("mid_fs",   32'(a_fs), 32'd0);
    chk("mid_busy", 32'(a_busy), 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_ready_after", 32'(a_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("mid_quiet_ov", 32'(a_ov), 32'd0);
    end

    // Producer stall: next word held valid through the whole first word.
    w = 16'h00FF;
    a_valid = 1'b1; a_par = w;
    step();
    a_par = 16'h8001;
    for (int k = 0; k < int'(BA); k++) begin
      exp_bit = (k < 16) ? w[k] : 1'b0;
      chk("stall_ready", 32'(a_ready), 32'(k == int'(BA) - 1));
      chk("stall_fs",    32'(a_fs), 32'(k == 0));
      chk("stall_ser",   32'(a_ser), 32'(exp_bit));
      step();
    end
    a_valid = 1'b0;
    w = 16'h8001;
    chk("stall_w2_fs",  32'(a_fs), 32'd1);
    chk("stall_w2_ser", 32'(a_ser), 32'd1);
    for (int k = 1; k < int'(BA); k++) begin
      step();
      exp_bit = (k < 16) ? w[k] : 1'b0;
      chk("stall_w2_beat", 32'(a_ser), 32'(exp_bit));
    end
    step();
    chk("stall_end_ov", 32'(a_ov), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
